// File: rtl/fs_en_pacer.sv
// fs_en_pacer: per-channel event decimator, credit buffer and paced fs_en pulse generator.
// Every channel is an independent copy running in the sys_clk domain.
module fs_en_pacer #(
   parameter  int NUM_CH    = 2,
   parameter  int DIV_WIDTH = 8,
   parameter  int CNT_DEPTH = 32,
   parameter  int MIN_GAP   = 1,
   localparam int CW        = $clog2(CNT_DEPTH + 1)
) (
   input  logic                        sys_clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        clr_overflow,
   input  logic [NUM_CH*DIV_WIDTH-1:0] div_ratio,
   input  logic [NUM_CH-1:0]           ev_in,
   output logic [NUM_CH-1:0]           fs_en,
   output logic [NUM_CH*CW-1:0]        pending,
   output logic [NUM_CH-1:0]           overflow
);

   localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (MIN_GAP > 2) ? GW'(MIN_GAP - 2) : {GW{1'b0}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      GAP  = 2'd2
   } state_t;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DIV_WIDTH-1:0] ratio_s, ratio_m1_s;
      logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
      logic [CW-1:0]        pend_q, pend_d;
      logic [GW-1:0]        gap_q, gap_d;
      logic                 ovf_q, ovf_d, ovf_set_s;
      logic                 fs_en_q, fs_en_d;
      logic                 qual_s, fire_s, ready_s;
      state_t               state_q, state_d;

      assign ratio_s    = div_ratio[g*DIV_WIDTH +: DIV_WIDTH];
      assign ratio_m1_s = (ratio_s == {DIV_WIDTH{1'b0}}) ? {DIV_WIDTH{1'b0}}
                                                         : ratio_s - DIV_WIDTH'(1);
      // >= rather than == so a lowered ratio qualifies at once instead of wrapping
      assign qual_s     = enable & ev_in[g] & (div_cnt_q >= ratio_m1_s);

      // Decimator counter next state
      always_comb begin
         div_cnt_d = div_cnt_q;
         if (enable && ev_in[g]) begin
            if (qual_s) begin
               div_cnt_d = {DIV_WIDTH{1'b0}};
            end else begin
               div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
         end else begin
            div_cnt_d = div_cnt_q;
         end
      end

      // Pacer next state; leaving FIRE/GAP re-evaluates the launch in the same cycle
      always_comb begin
         state_d = state_q;
         gap_d   = gap_q;
         ready_s = 1'b0;
         fire_s  = 1'b0;
         case (state_q)
            IDLE: ready_s = 1'b1;
            FIRE: begin
               if (MIN_GAP <= 1) begin
                  ready_s = 1'b1;
               end else begin
                  state_d = GAP;
                  gap_d   = GAP_LOAD;
               end
            end
            GAP: begin
               if (gap_q == {GW{1'b0}}) begin
                  ready_s = 1'b1;
               end else begin
                  gap_d = gap_q - GW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
         if (ready_s) begin
            if (enable && (pend_q != {CW{1'b0}})) begin
               state_d = FIRE;
               fire_s  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end else begin
            fire_s = 1'b0;
         end
         fs_en_d = fire_s;
      end

      // Credit counter and sticky overflow next state
      always_comb begin
         pend_d    = pend_q;
         ovf_set_s = 1'b0;
         if (qual_s && !fire_s) begin
            if (pend_q == CW'(CNT_DEPTH)) begin
               ovf_set_s = 1'b1;
            end else begin
               pend_d = pend_q + CW'(1);
            end
         end else if (fire_s && !qual_s) begin
            pend_d = pend_q - CW'(1);
         end else begin
            pend_d = pend_q;
         end
         ovf_d = ovf_set_s | (ovf_q & ~clr_overflow);
      end

      // Channel state registers
      always_ff @(posedge sys_clk or negedge rst_n) begin
         if (!rst_n) begin
            div_cnt_q <= {DIV_WIDTH{1'b0}};
            pend_q    <= {CW{1'b0}};
            gap_q     <= {GW{1'b0}};
            ovf_q     <= 1'b0;
            fs_en_q   <= 1'b0;
            state_q   <= IDLE;
         end else begin
            div_cnt_q <= div_cnt_d;
            pend_q    <= pend_d;
            gap_q     <= gap_d;
            ovf_q     <= ovf_d;
            fs_en_q   <= fs_en_d;
            state_q   <= state_d;
         end
      end

      assign fs_en[g]            = fs_en_q;
      assign pending[g*CW +: CW] = pend_q;
      assign overflow[g]         = ovf_q;
   end

endmodule
